// File: rtl/lottery_pkg.sv
// Shared types for the lottery matcher: FSM states and prize codes.
package lottery_pkg;

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        IDLE   = 3'd1,
        ENTRY  = 3'd2,
        RESULT = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        P1   = 2'b01,
        P2   = 2'b10,
        MISS = 2'b11
    } premio_t;

endpackage

// File: rtl/lottery_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module lottery_sat_counter #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/lottery_matcher.sv
// Lottery ticket matcher: loads a draw, scores tickets by prefix match, counts prizes.
// The ticket is graded on the edge entering RESULT, so premio/p1/p2 are already updated during the pulse.
module lottery_matcher
    import lottery_pkg::*;
#(
    parameter int N_DIGITS    = 5,
    parameter int DIGIT_W     = 4,
    parameter int P2_MIN      = 3,
    parameter int CNT_W       = 5,
    parameter int MAX_TICKETS = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               draw_we,
    input  logic [DIGIT_W-1:0] draw_digit,
    input  logic               insere,
    input  logic [DIGIT_W-1:0] numero,
    input  logic               fim,
    input  logic               fim_jogo,
    output logic [1:0]         premio,
    output logic               premio_valid,
    output logic [CNT_W-1:0]   p1,
    output logic [CNT_W-1:0]   p2,
    output logic               ready,
    output logic               game_over
);

    localparam int IDX_W  = $clog2(N_DIGITS + 1);
    localparam int AW     = $clog2(N_DIGITS);
    localparam int TCNT_W = $clog2(MAX_TICKETS + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [IDX_W-1:0]  FULL     = IDX_W'(N_DIGITS);
    localparam logic [IDX_W-1:0]  P2_THR   = IDX_W'(P2_MIN);
    localparam logic [TCNT_W-1:0] TMAX     = TCNT_W'(MAX_TICKETS);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    pos_q, pos_d;
    logic [IDX_W-1:0]    hits_q, hits_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    premio_t             premio_q, premio_d;
    logic                end_q, end_d;
    logic [DIGIT_W-1:0]  draw_q [N_DIGITS];

    logic                draw_wr;
    logic [AW-1:0]       draw_wa;
    logic                inc_p1;
    logic                inc_p2;
    logic                clr_cnt;
    logic                hit_now;
    logic [IDX_W-1:0]    hits_ins;
    logic [IDX_W-1:0]    pos_ins;
    logic [IDX_W-1:0]    eval_hits;
    logic                last;
    premio_t             grade_v;

    function automatic premio_t grade(input logic [IDX_W-1:0] h);
        if (h == FULL) begin
            return P1;
        end else if (h >= P2_THR) begin
            return P2;
        end
        return MISS;
    endfunction

    // A digit only scores while the ticket still matches the draw from position 0 onward.
    assign hit_now  = (hits_q == pos_q) && (numero == draw_q[pos_q[AW-1:0]]);
    assign hits_ins = hits_q + IDX_W'(hit_now);
    assign pos_ins  = pos_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        hits_d    = hits_q;
        tcnt_d    = tcnt_q;
        premio_d  = premio_q;
        end_d     = end_q;
        draw_wr   = 1'b0;
        draw_wa   = idx_q[AW-1:0];
        inc_p1    = 1'b0;
        inc_p2    = 1'b0;
        clr_cnt   = 1'b0;
        eval_hits = hits_q;
        last      = 1'b0;
        grade_v   = MISS;

        case (state_q)
            LOAD: begin
                if (draw_we) begin
                    draw_wr = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            IDLE, ENTRY: begin
                // fim_jogo with no digit in flight in IDLE ends the game without grading.
                if ((state_q == IDLE) && fim_jogo && !insere) begin
                    state_d = DONE;
                end else begin
                    last = fim || fim_jogo;
                    if (fim_jogo) begin
                        end_d = 1'b1;
                    end
                    if (insere) begin
                        eval_hits = hits_ins;
                        hits_d    = hits_ins;
                        pos_d     = pos_ins;
                        state_d   = ENTRY;
                        if (pos_ins == FULL) begin
                            last = 1'b1;
                        end
                    end
                    if (last) begin
                        grade_v  = grade(eval_hits);
                        premio_d = grade_v;
                        inc_p1   = (grade_v == P1);
                        inc_p2   = (grade_v == P2);
                        pos_d    = '0;
                        hits_d   = '0;
                        tcnt_d   = tcnt_q + 1'b1;
                        state_d  = RESULT;
                    end
                end
            end

            RESULT: begin
                end_d = 1'b0;
                if ((tcnt_q == TMAX) || end_q || fim_jogo) begin
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end

            DONE: begin
                if (draw_we) begin
                    draw_wr  = 1'b1;
                    draw_wa  = '0;
                    idx_d    = IDX_W'(1);
                    clr_cnt  = 1'b1;
                    tcnt_d   = '0;
                    premio_d = NONE;
                    state_d  = LOAD;
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= LOAD;
            idx_q    <= '0;
            pos_q    <= '0;
            hits_q   <= '0;
            tcnt_q   <= '0;
            premio_q <= NONE;
            end_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pos_q    <= pos_d;
            hits_q   <= hits_d;
            tcnt_q   <= tcnt_d;
            premio_q <= premio_d;
            end_q    <= end_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                draw_q[i] <= '0;
            end
        end else if (draw_wr) begin
            draw_q[draw_wa] <= draw_digit;
        end
    end

    lottery_sat_counter #(.W(CNT_W)) u_p1_cnt (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (clr_cnt),
        .inc_i   (inc_p1),
        .count_o (p1)
    );

    lottery_sat_counter #(.W(CNT_W)) u_p2_cnt (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (clr_cnt),
        .inc_i   (inc_p2),
        .count_o (p2)
    );

    assign premio       = premio_q;
    assign premio_valid = (state_q == RESULT);
    assign ready        = (state_q == IDLE) || (state_q == ENTRY);
    assign game_over    = (state_q == DONE);

endmodule

// File: tb/tb_lottery_matcher.sv
// Directed bench: default-parameter matcher plus a CNT_W=2/MAX_TICKETS=6 copy for saturation.
module tb_lottery_matcher;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       draw_we = 1'b0;
    logic [3:0] draw_digit = '0;
    logic       insere = 1'b0;
    logic [3:0] numero = '0;
    logic       fim = 1'b0;
    logic       fim_jogo = 1'b0;

    logic [1:0] premio, premio2;
    logic       premio_valid, premio_valid2;
    logic [4:0] p1, p2;
    logic [1:0] p1_2, p2_2;
    logic       ready, ready2;
    logic       game_over, game_over2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    lottery_matcher dut (
        .clock        (clock),
        .reset        (reset),
        .draw_we      (draw_we),
        .draw_digit   (draw_digit),
        .insere       (insere),
        .numero       (numero),
        .fim          (fim),
        .fim_jogo     (fim_jogo),
        .premio       (premio),
        .premio_valid (premio_valid),
        .p1           (p1),
        .p2           (p2),
        .ready        (ready),
        .game_over    (game_over)
    );

    lottery_matcher #(.CNT_W(2), .MAX_TICKETS(6)) dut_sat (
        .clock        (clock),
        .reset        (reset),
        .draw_we      (draw_we),
        .draw_digit   (draw_digit),
        .insere       (insere),
        .numero       (numero),
        .fim          (fim),
        .fim_jogo     (fim_jogo),
        .premio       (premio2),
        .premio_valid (premio_valid2),
        .p1           (p1_2),
        .p2           (p2_2),
        .ready        (ready2),
        .game_over    (game_over2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr_draw(input logic [3:0] d);
        draw_we = 1'b1;
        draw_digit = d;
        cyc();
        draw_we = 1'b0;
    endtask

    task automatic load_draw(input logic [19:0] v);
        for (int i = 4; i >= 0; i--) wr_draw(v[i*4 +: 4]);
    endtask

    task automatic ins(input logic [3:0] d);
        insere = 1'b1;
        numero = d;
        cyc();
        insere = 1'b0;
    endtask

    task automatic ticket(input logic [19:0] v);
        for (int i = 4; i >= 0; i--) ins(v[i*4 +: 4]);
    endtask

    task automatic pulse_fim();
        fim = 1'b1;
        cyc();
        fim = 1'b0;
    endtask

    task automatic pulse_fim_jogo();
        fim_jogo = 1'b1;
        cyc();
        fim_jogo = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        logic [19:0] draw_v;
        draw_v = {4'd5, 4'd3, 4'd8, 4'd2, 4'd0};

        do_reset();
        check("rst_premio", premio, 0);
        check("rst_valid", premio_valid, 0);
        check("rst_p1", p1, 0);
        check("rst_p2", p2, 0);
        check("rst_ready", ready, 0);
        check("rst_game_over", game_over, 0);

        ins(4'd5);
        check("load_ignores_insere", ready, 0);
        load_draw(draw_v);
        check("loaded_ready", ready, 1);

        ticket({4'd5, 4'd3, 4'd8, 4'd2, 4'd0});
        check("t1_premio", premio, 1);
        check("t1_valid", premio_valid, 1);
        check("t1_p1", p1, 1);
        cyc();
        check("t1_pulse_one_cycle", premio_valid, 0);
        check("t1_premio_hold", premio, 1);

        ticket({4'd5, 4'd3, 4'd8, 4'd7, 4'd0});
        check("t2_premio", premio, 2);
        check("t2_p2", p2, 1);
        cyc();

        ticket({4'd5, 4'd3, 4'd1, 4'd2, 4'd0});
        check("t3_premio", premio, 3);
        check("t3_p1", p1, 1);
        check("t3_p2", p2, 1);
        cyc();

        ins(4'd5); ins(4'd3); ins(4'd8);
        check("t4_no_pulse_yet", premio_valid, 0);
        pulse_fim();
        check("t4_premio", premio, 2);
        check("t4_valid", premio_valid, 1);
        check("t4_p2", p2, 2);
        cyc();

        pulse_fim();
        check("t5_empty_premio", premio, 3);
        check("t5_empty_valid", premio_valid, 1);
        cyc();
        check("t5_game_over", game_over, 1);
        check("t5_ready", ready, 0);

        ins(4'd5);
        pulse_fim();
        check("done_ign_valid", premio_valid, 0);
        check("done_hold_premio", premio, 3);
        check("done_hold_p1", p1, 1);
        check("done_hold_p2", p2, 2);

        wr_draw(4'd5);
        check("newgame_p1", p1, 0);
        check("newgame_p2", p2, 0);
        check("newgame_premio", premio, 0);
        check("newgame_game_over", game_over, 0);
        check("newgame_in_load", ready, 0);
        wr_draw(4'd3); wr_draw(4'd8); wr_draw(4'd2); wr_draw(4'd0);
        check("newgame_ready", ready, 1);
        ticket(draw_v);
        check("newgame_t1_premio", premio, 1);
        check("newgame_t1_p1", p1, 1);
        cyc();

        ins(4'd5); ins(4'd3);
        reset = 1'b1;
        #2;
        check("midrst_premio", premio, 0);
        check("midrst_valid", premio_valid, 0);
        check("midrst_p1", p1, 0);
        check("midrst_ready", ready, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc();
        check("midrst_no_pulse", premio_valid, 0);
        load_draw(draw_v);
        check("reload_ready", ready, 1);

        ins(4'd5); ins(4'd3);
        insere = 1'b1; numero = 4'd8; fim = 1'b1;
        cyc();
        insere = 1'b0; fim = 1'b0;
        check("fim_ins_premio", premio, 2);
        check("fim_ins_p2", p2, 1);
        cyc();

        ins(4'd5); ins(4'd3); ins(4'd8);
        pulse_fim_jogo();
        check("fj_entry_premio", premio, 2);
        check("fj_entry_valid", premio_valid, 1);
        cyc();
        check("fj_entry_game_over", game_over, 1);

        do_reset();
        load_draw(draw_v);
        pulse_fim_jogo();
        check("fj_idle_game_over", game_over, 1);
        check("fj_idle_no_pulse", premio_valid, 0);

        do_reset();
        load_draw(draw_v);
        for (int k = 1; k <= 6; k++) begin
            ticket(draw_v);
            check("sat_valid", premio_valid2, 1);
            check("sat_p1", p1_2, (k < 3) ? k : 3);
            cyc();
        end
        check("sat_game_over", game_over2, 1);
        check("dflt_p1_after_five", p1, 5);
        check("dflt_game_over", game_over, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lottery_matcher.md
LOTTERY_MATCHER -- requirements
Module: lottery_matcher

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 5, giving digits per draw and per ticket (legal range 2..16).
REQ-002 The block SHALL have parameter DIGIT_W, default 4, giving the bit width of one digit.
REQ-003 The block SHALL have parameter P2_MIN, default 3, giving the minimum prefix-hit count for second prize (legal range 1..N_DIGITS-1).
REQ-004 The block SHALL have parameter CNT_W, default 5, giving the width of the prize counters.
REQ-005 The block SHALL have parameter MAX_TICKETS, default 5, giving the number of tickets per game.
REQ-006 The block SHALL have port clock, input, 1 bit, the rising-edge clock.
REQ-007 The block SHALL have port reset, input, 1 bit, the asynchronous active-high reset.
REQ-008 The block SHALL have port draw_we, input, 1 bit, which writes one draw digit.
REQ-009 The block SHALL have port draw_digit, input, DIGIT_W bits, the draw digit value.
REQ-010 The block SHALL have port insere, input, 1 bit, which enters one ticket digit.
REQ-011 The block SHALL have port numero, input, DIGIT_W bits, the ticket digit value.
REQ-012 The block SHALL have port fim, input, 1 bit, which ends the current ticket early.
REQ-013 The block SHALL have port fim_jogo, input, 1 bit, which ends the game.
REQ-014 The block SHALL have port premio, output, 2 bits, the last result: 00 none yet, 01 first prize, 10 second prize, 11 no prize.
REQ-015 The block SHALL have port premio_valid, output, 1 bit, a one-cycle pulse marking a new premio value.
REQ-016 The block SHALL have ports p1 and p2, output, CNT_W bits each, counting first and second prizes.
REQ-017 The block SHALL have port ready, output, 1 bit, which is high in IDLE and ENTRY.
REQ-018 The block SHALL have port game_over, output, 1 bit, which is high in DONE.

Function
REQ-019 The FSM SHALL have states LOAD, IDLE, ENTRY, RESULT and DONE, and reset SHALL enter LOAD with draw index 0.
REQ-020 In LOAD, each draw_we cycle SHALL store draw_digit at draw[idx] and increment idx; after the N_DIGITS-th write the FSM SHALL go to IDLE.
REQ-021 draw_we SHALL be ignored in IDLE, ENTRY and RESULT.
REQ-022 On insere in IDLE or ENTRY, the block SHALL compare numero with draw[pos], increment the hit count only when it equals pos and the digit matches (prefix match), increment pos, and move to ENTRY.
REQ-023 The insere that brings pos to N_DIGITS, or fim, SHALL move the FSM to RESULT on the next edge.
REQ-024 When fim and insere are asserted in the same cycle, the digit SHALL be counted first and the ticket then evaluated.
REQ-025 fim in IDLE with no digits entered SHALL evaluate an empty ticket, giving result 11.
REQ-026 RESULT SHALL last exactly one cycle with premio_valid=1, so latency is one cycle from the last digit or fim to the pulse.
REQ-027 In RESULT, hits==N_DIGITS SHALL give premio 01 and p1 increment; hits>=P2_MIN SHALL give 10 and p2 increment; otherwise premio SHALL be 11.
REQ-028 p1 and p2 SHALL saturate at 2^CNT_W-1.
REQ-029 premio SHALL hold its value until the next RESULT.
REQ-030 RESULT SHALL clear pos and hits and increment the ticket count.
REQ-031 After RESULT, the FSM SHALL go to DONE if the ticket count equals MAX_TICKETS or an end of game is pending, otherwise to IDLE.
REQ-032 insere, fim and fim_jogo SHALL be ignored in LOAD; insere and fim SHALL be ignored in RESULT.
REQ-033 fim_jogo in IDLE SHALL move the FSM to DONE on the next edge.
REQ-034 fim_jogo in ENTRY SHALL act as fim, with DONE following RESULT.
REQ-035 fim_jogo in RESULT SHALL force DONE next.
REQ-036 In DONE, counters and premio SHALL hold; insere, fim and fim_jogo SHALL be ignored.
REQ-037 draw_we in DONE SHALL start a new game: store draw_digit at draw[0], set idx=1, clear p1, p2 and the ticket count, set premio=00, and enter LOAD.

Reset
REQ-038 Reset SHALL asynchronously set state=LOAD, idx=0, pos=0, hits=0, ticket count=0, premio=00, premio_valid=0, p1=0, p2=0, ready=0, game_over=0, and all draw digits to 0.
REQ-039 Reset asserted mid-ticket or mid-load SHALL discard all progress, with no result pulse.

Structure
REQ-040 The state enumeration and premio codes (NONE, P1, P2, MISS) SHALL live in shared package lottery_pkg.
REQ-041 Prize counting SHALL use sub-module lottery_sat_counter (increment, clear, saturate), instantiated twice.

Verification
REQ-042 Load draw 5,3,8,2,0, then enter 5,3,8,2,0 -> one cycle after the last insere, premio=01, premio_valid=1, p1=1.
REQ-043 Same draw, enter 5,3,8,7,0 -> premio=10 and p2=1; enter 5,3,1,2,0 -> premio=11 with p1 and p2 unchanged.
REQ-044 Enter 5,3,8 then pulse fim -> premio=10; fim alone in IDLE -> premio=11.
REQ-045 Five tickets -> game_over=1 and further insere ignored; then draw_we -> p1=p2=0, premio=00, FSM in LOAD.
REQ-046 With CNT_W=2 and MAX_TICKETS=6, six first-prize tickets -> p1 saturates at 3.
REQ-047 Reset asserted after 2 digits -> all outputs 0 and the block needs a full reload; fim_jogo in ENTRY after 5,3,8 -> premio=10, then game_over=1.
